// File: rtl/atomic_ctrl_pkg.sv
// atomic_ctrl_pkg: state encoding and parameter defaults shared by atomic_counter_ctrl and rr_arbiter.
package atomic_ctrl_pkg;
    localparam int NREQ_DEF     = 4;
    localparam int DATABUS_DEF  = 32;
    localparam int COUNTLEN_DEF = 2 * DATABUS_DEF;
    localparam int TIMEOUT_DEF  = 15;
    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_HI,
        RESP
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from i_ptr upward with wrap-around.
module rr_arbiter
    import atomic_ctrl_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx
);
    logic          w_found;
    logic [PW-1:0] w_j;
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = PW'((int'(i_ptr) + i) % NREQ);
            if (!w_found && i_req[w_j]) begin
                w_found     = 1'b1;
                o_gnt[w_j]  = 1'b1;
                o_idx       = w_j;
            end
        end
    end
endmodule

// File: rtl/atomic_counter_ctrl.sv
// atomic_counter_ctrl: grants one requester, reads a COUNTLEN counter as lo then atomic hi half, returns it.
// Define ATOMIC_CTRL_TIMEOUT_EN to abort a wait after TIMEOUT cycles with rsp_err_o=1 and zero data.
module atomic_counter_ctrl
    import atomic_ctrl_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int DATABUS  = DATABUS_DEF,
    parameter int COUNTLEN = 2 * DATABUS,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [COUNTLEN-1:0] rsp_data_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    output logic                cnt_req_o,
    output logic                cnt_atomic_o,
    input  logic                cnt_ack_i,
    input  logic [DATABUS-1:0]  cnt_data_i
);
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || COUNTLEN != 2 * DATABUS || TIMEOUT < 1) begin : g_param_err
        $error("atomic_counter_ctrl: unsupported parameter combination");
    end

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [NREQ-1:0]     r_gnt;
    logic                r_rsp_valid;
    logic [COUNTLEN-1:0] r_rsp_data;
    logic                r_cnt_req;
    logic                r_cnt_atomic;
    logic [NREQ-1:0]     w_gnt;
    logic [PW-1:0]       w_idx;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

`ifdef ATOMIC_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic          r_err;
    logic [TW-1:0] r_tmo;
    logic          w_tmo_hit;
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));
    assign rsp_err_o = r_err;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_cnt_req    <= 1'b0;
            r_cnt_atomic <= 1'b0;
`ifdef ATOMIC_CTRL_TIMEOUT_EN
            r_err        <= 1'b0;
            r_tmo        <= '0;
`endif
        end else begin
            // counter-port strobes are single-cycle pulses raised on entry to REQ_LO/REQ_HI
            r_cnt_req    <= 1'b0;
            r_cnt_atomic <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req_i) begin
                        r_gnt     <= w_gnt;
                        r_ptr     <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                        r_cnt_req <= 1'b1;
                        r_state   <= REQ_LO;
`ifdef ATOMIC_CTRL_TIMEOUT_EN
                        r_err     <= 1'b0;
`endif
                    end
                end
                REQ_LO: begin
                    r_state <= WAIT_LO;
`ifdef ATOMIC_CTRL_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                end
                WAIT_LO: begin
                    if (cnt_ack_i) begin
                        r_rsp_data[DATABUS-1:0] <= cnt_data_i;
                        r_cnt_req               <= 1'b1;
                        r_cnt_atomic            <= 1'b1;
                        r_state                 <= REQ_HI;
                    end
`ifdef ATOMIC_CTRL_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_rsp_data  <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                REQ_HI: begin
                    r_state <= WAIT_HI;
`ifdef ATOMIC_CTRL_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                end
                WAIT_HI: begin
                    if (cnt_ack_i) begin
                        r_rsp_data[COUNTLEN-1:DATABUS] <= cnt_data_i;
                        r_rsp_valid                    <= 1'b1;
                        r_state                        <= RESP;
                    end
`ifdef ATOMIC_CTRL_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_rsp_data  <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_gnt       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt_o        = r_gnt;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_data_o   = r_rsp_data;
    assign busy_o       = (r_state != IDLE);
    assign cnt_req_o    = r_cnt_req;
    assign cnt_atomic_o = r_cnt_atomic;
endmodule
